// File: rtl/skin_pkg.sv
// Shared definitions for the skin-mask statistics block: FSM state encoding,
// default colour thresholds and frame geometry, and counter width helpers.
package skin_pkg;

  // Frame tracking state: IDLE waits for sof, ACTIVE accumulates a frame.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Default sample width and frame geometry.
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_IMG_W  = 640;
  localparam int DEF_IMG_H  = 480;

  // Default YCbCr skin window (inclusive bounds, unsigned samples).
  localparam int DEF_CB_MIN = 77;
  localparam int DEF_CB_MAX = 127;
  localparam int DEF_CR_MIN = 133;
  localparam int DEF_CR_MAX = 173;
  localparam int DEF_Y_MIN  = 40;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/skin_classify.sv
// Combinational skin classifier: Y above a floor and Cb/Cr inside an
// inclusive window. The parent registers the result.
module skin_classify
  import skin_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CB_MIN = DEF_CB_MIN,
  parameter int CB_MAX = DEF_CB_MAX,
  parameter int CR_MIN = DEF_CR_MIN,
  parameter int CR_MAX = DEF_CR_MAX,
  parameter int Y_MIN  = DEF_Y_MIN
) (
  input  logic [WIDTH-1:0] i_luma,
  input  logic [WIDTH-1:0] i_cb,
  input  logic [WIDTH-1:0] i_cr,
  output logic             o_skin
);

  localparam logic [WIDTH-1:0] C_CB_MIN = WIDTH'(CB_MIN);
  localparam logic [WIDTH-1:0] C_CB_MAX = WIDTH'(CB_MAX);
  localparam logic [WIDTH-1:0] C_CR_MIN = WIDTH'(CR_MIN);
  localparam logic [WIDTH-1:0] C_CR_MAX = WIDTH'(CR_MAX);
  localparam logic [WIDTH-1:0] C_Y_MIN  = WIDTH'(Y_MIN);

  logic w_y_ok;
  logic w_cb_ok;
  logic w_cr_ok;

  assign w_y_ok  = (i_luma >= C_Y_MIN);
  assign w_cb_ok = (i_cb >= C_CB_MIN) && (i_cb <= C_CB_MAX);
  assign w_cr_ok = (i_cr >= C_CR_MIN) && (i_cr <= C_CR_MAX);
  assign o_skin  = w_y_ok && w_cb_ok && w_cr_ok;

endmodule

// File: rtl/skin_mask_stats.sv
// Skin mask generator with per-frame statistics (skin pixel count and sums of
// column/row indices). Define SKIN_BBOX_EN to also publish the bounding box
// of skin pixels; without it the bbox ports and logic are absent.
module skin_mask_stats
  import skin_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int CB_MIN = DEF_CB_MIN,
  parameter int CB_MAX = DEF_CB_MAX,
  parameter int CR_MIN = DEF_CR_MIN,
  parameter int CR_MAX = DEF_CR_MAX,
  parameter int Y_MIN  = DEF_Y_MIN
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         pix_valid,
  input  logic                                         sof,
  input  logic [WIDTH-1:0]                             luma_ch,
  input  logic [WIDTH-1:0]                             cb_ch,
  input  logic [WIDTH-1:0]                             cr_ch,
  output logic                                         mask_valid,
  output logic                                         mask_bit,
  output logic                                         frame_done,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0]             pix_count,
  output logic [$clog2(IMG_W*IMG_W*IMG_H):0]           sum_x,
  output logic [$clog2(IMG_W*IMG_W*IMG_H):0]           sum_y
`ifdef SKIN_BBOX_EN
  ,
  output logic [clog2_min1(IMG_W)-1:0]                 bbox_xmin,
  output logic [clog2_min1(IMG_W)-1:0]                 bbox_xmax,
  output logic [clog2_min1(IMG_H)-1:0]                 bbox_ymin,
  output logic [clog2_min1(IMG_H)-1:0]                 bbox_ymax
`endif
);

  localparam int XW = clog2_min1(IMG_W);
  localparam int YW = clog2_min1(IMG_H);
  localparam int CW = $clog2(IMG_W*IMG_H+1);
  localparam int SW = $clog2(IMG_W*IMG_W*IMG_H) + 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  // Frame state, position and working accumulators
  state_t          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_sx;
  logic [SW-1:0]   r_sy;

  // Published results and registered mask
  logic            r_mask_valid;
  logic            r_mask_bit;
  logic            r_frame_done;
  logic [CW-1:0]   r_pix_count;
  logic [SW-1:0]   r_sum_x;
  logic [SW-1:0]   r_sum_y;

  logic            w_skin;
  logic            w_take;
  logic            w_last;
  logic [XW-1:0]   w_x_cur;
  logic [YW-1:0]   w_y_cur;
  logic [CW-1:0]   w_cnt_next;
  logic [SW-1:0]   w_sx_next;
  logic [SW-1:0]   w_sy_next;

  skin_classify #(
    .WIDTH  (WIDTH),
    .CB_MIN (CB_MIN),
    .CB_MAX (CB_MAX),
    .CR_MIN (CR_MIN),
    .CR_MAX (CR_MAX),
    .Y_MIN  (Y_MIN)
  ) u_classify (
    .i_luma (luma_ch),
    .i_cb   (cb_ch),
    .i_cr   (cr_ch),
    .o_skin (w_skin)
  );

  // A pixel contributes to a frame when it starts one or arrives mid-frame;
  // sof always restarts at (0,0) with cleared accumulators, so the base
  // values are selected here rather than cleared a cycle early.
  always_comb begin
    w_take     = pix_valid && (sof || (r_state == ACTIVE));
    w_x_cur    = sof ? '0 : r_x;
    w_y_cur    = sof ? '0 : r_y;
    w_last     = (w_x_cur == X_LAST) && (w_y_cur == Y_LAST);
    w_cnt_next = (sof ? '0 : r_cnt) + CW'(w_skin);
    w_sx_next  = (sof ? '0 : r_sx) + (w_skin ? SW'(w_x_cur) : '0);
    w_sy_next  = (sof ? '0 : r_sy) + (w_skin ? SW'(w_y_cur) : '0);
  end

`ifdef SKIN_BBOX_EN
  logic            r_any;
  logic [XW-1:0]   r_xmin;
  logic [XW-1:0]   r_xmax;
  logic [YW-1:0]   r_ymin;
  logic [YW-1:0]   r_ymax;
  logic [XW-1:0]   r_bxmin;
  logic [XW-1:0]   r_bxmax;
  logic [YW-1:0]   r_bymin;
  logic [YW-1:0]   r_bymax;

  logic            w_any_base;
  logic            w_any_next;
  logic [XW-1:0]   w_xmin_next;
  logic [XW-1:0]   w_xmax_next;
  logic [YW-1:0]   w_ymin_next;
  logic [YW-1:0]   w_ymax_next;

  // Running bounding box; the first skin pixel of a frame seeds all four edges.
  always_comb begin
    w_any_base  = sof ? 1'b0 : r_any;
    w_any_next  = w_any_base || w_skin;
    w_xmin_next = sof ? '0 : r_xmin;
    w_xmax_next = sof ? '0 : r_xmax;
    w_ymin_next = sof ? '0 : r_ymin;
    w_ymax_next = sof ? '0 : r_ymax;
    if (w_skin) begin
      if (!w_any_base || (w_x_cur < r_xmin)) w_xmin_next = w_x_cur;
      if (!w_any_base || (w_x_cur > r_xmax)) w_xmax_next = w_x_cur;
      if (!w_any_base || (w_y_cur < r_ymin)) w_ymin_next = w_y_cur;
      if (!w_any_base || (w_y_cur > r_ymax)) w_ymax_next = w_y_cur;
    end
  end

  // Working and published bounding box; empty frames publish zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_any   <= 1'b0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
      r_bxmin <= '0;
      r_bxmax <= '0;
      r_bymin <= '0;
      r_bymax <= '0;
    end else if (w_take) begin
      r_any  <= w_any_next;
      r_xmin <= w_xmin_next;
      r_xmax <= w_xmax_next;
      r_ymin <= w_ymin_next;
      r_ymax <= w_ymax_next;
      if (w_last) begin
        r_bxmin <= w_any_next ? w_xmin_next : '0;
        r_bxmax <= w_any_next ? w_xmax_next : '0;
        r_bymin <= w_any_next ? w_ymin_next : '0;
        r_bymax <= w_any_next ? w_ymax_next : '0;
      end
    end
  end

  assign bbox_xmin = r_bxmin;
  assign bbox_xmax = r_bxmax;
  assign bbox_ymin = r_bymin;
  assign bbox_ymax = r_bymax;
`endif

  // Mask output tracks every valid pixel with one cycle of latency, in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask_valid <= 1'b0;
      r_mask_bit   <= 1'b0;
    end else begin
      r_mask_valid <= pix_valid;
      r_mask_bit   <= pix_valid && w_skin;
    end
  end

  // Frame FSM: advance position, accumulate, and publish on the last pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_cnt        <= '0;
      r_sx         <= '0;
      r_sy         <= '0;
      r_frame_done <= 1'b0;
      r_pix_count  <= '0;
      r_sum_x      <= '0;
      r_sum_y      <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_take) begin
        r_cnt <= w_cnt_next;
        r_sx  <= w_sx_next;
        r_sy  <= w_sy_next;
        if (w_last) begin
          r_state      <= IDLE;
          r_x          <= '0;
          r_y          <= '0;
          r_pix_count  <= w_cnt_next;
          r_sum_x      <= w_sx_next;
          r_sum_y      <= w_sy_next;
          r_frame_done <= 1'b1;
        end else begin
          r_state <= ACTIVE;
          if (w_x_cur == X_LAST) begin
            r_x <= '0;
            r_y <= w_y_cur + YW'(1);
          end else begin
            r_x <= w_x_cur + XW'(1);
            r_y <= w_y_cur;
          end
        end
      end
    end
  end

  assign mask_valid = r_mask_valid;
  assign mask_bit   = r_mask_bit;
  assign frame_done = r_frame_done;
  assign pix_count  = r_pix_count;
  assign sum_x      = r_sum_x;
  assign sum_y      = r_sum_y;

endmodule

// File: tb/tb_skin_mask_stats.sv
// Scoreboard bench for skin_mask_stats on a 4x2 frame. Stimulus pushes
// expected mask bits and frame statistics into queues; a monitor on the
// falling edge pops and compares whenever the DUT presents mask_valid or
// frame_done. Define SKIN_BBOX_EN to also check the bounding box.
module tb_skin_mask_stats;

  localparam int IW = 4;
  localparam int IH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_valid;
  logic       sof;
  logic [7:0] luma_ch;
  logic [7:0] cb_ch;
  logic [7:0] cr_ch;
  logic       mask_valid;
  logic       mask_bit;
  logic       frame_done;
  logic [3:0] pix_count;
  logic [5:0] sum_x;
  logic [5:0] sum_y;
`ifdef SKIN_BBOX_EN
  logic [1:0] bbox_xmin;
  logic [1:0] bbox_xmax;
  logic [0:0] bbox_ymin;
  logic [0:0] bbox_ymax;
`endif

  always #5 clk = ~clk;

  skin_mask_stats #(
    .WIDTH (8),
    .IMG_W (IW),
    .IMG_H (IH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .luma_ch    (luma_ch),
    .cb_ch      (cb_ch),
    .cr_ch      (cr_ch),
    .mask_valid (mask_valid),
    .mask_bit   (mask_bit),
    .frame_done (frame_done),
    .pix_count  (pix_count),
    .sum_x      (sum_x),
    .sum_y      (sum_y)
`ifdef SKIN_BBOX_EN
    ,
    .bbox_xmin  (bbox_xmin),
    .bbox_xmax  (bbox_xmax),
    .bbox_ymin  (bbox_ymin),
    .bbox_ymax  (bbox_ymax)
`endif
  );

  typedef struct {
    int cnt;
    int sx;
    int sy;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
  } frame_t;

  int     checks      = 0;
  int     errors      = 0;
  int     frames_seen = 0;
  logic   pv_prev     = 1'b0;
  logic   mask_q[$];
  frame_t frame_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected mask_valid is the previous cycle's pix_valid (outside reset).
  always @(posedge clk) pv_prev <= pix_valid && !rst;

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    if (!rst) begin
      chk("mask_valid_latency", {31'd0, mask_valid}, {31'd0, pv_prev});
      if (mask_valid === 1'b1) begin
        if (mask_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mask_unexpected: got mask_bit=%0d with nothing expected", mask_bit);
        end else begin
          chk("mask_bit", {31'd0, mask_bit}, {31'd0, mask_q.pop_front()});
        end
      end
      if (frame_done === 1'b1) begin
        frames_seen++;
        if (frame_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_done_unexpected: got pulse pix_count=%0d expected none", pix_count);
        end else begin
          frame_t f;
          f = frame_q.pop_front();
          chk("pix_count", 32'(pix_count), f.cnt);
          chk("sum_x", 32'(sum_x), f.sx);
          chk("sum_y", 32'(sum_y), f.sy);
`ifdef SKIN_BBOX_EN
          chk("bbox_xmin", 32'(bbox_xmin), f.xmin);
          chk("bbox_xmax", 32'(bbox_xmax), f.xmax);
          chk("bbox_ymin", 32'(bbox_ymin), f.ymin);
          chk("bbox_ymax", 32'(bbox_ymax), f.ymax);
`endif
        end
      end
    end
  end

  // One pixel for one clock; the expected mask bit enters the scoreboard.
  task automatic px(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                    input logic s, input logic em);
    pix_valid = 1'b1;
    sof       = s;
    luma_ch   = y;
    cb_ch     = cb;
    cr_ch     = cr;
    mask_q.push_back(em);
    $display("pixel Y=%0d Cb=%0d Cr=%0d sof=%0d expect_mask=%0d", y, cb, cr, s, em);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_frame(input int c, input int sx, input int sy,
                           input int x0, input int x1, input int y0, input int y1);
    frame_q.push_back('{c, sx, sy, x0, x1, y0, y1});
    $display("frame expect count=%0d sum_x=%0d sum_y=%0d bbox=(%0d,%0d,%0d,%0d)",
             c, sx, sy, x0, x1, y0, y1);
  endtask

  // Full sof-started frame; bit i of pattern marks pixel i = y*IW + x as skin.
  task automatic frame_pat(input logic [7:0] pattern, input int maxgap);
    logic [7:0] p;
    p = pattern;
    for (int i = 0; i < IW*IH; i++) begin
      px(8'd100, p[i] ? 8'd100 : 8'd0, 8'd150, (i == 0), p[i]);
      if (maxgap > 0) idle($urandom_range(maxgap, 0));
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_mask_valid"}, {31'd0, mask_valid}, 32'd0);
    chk({tag, "_mask_bit"}, {31'd0, mask_bit}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_pix_count"}, 32'(pix_count), 32'd0);
    chk({tag, "_sum_x"}, 32'(sum_x), 32'd0);
    chk({tag, "_sum_y"}, 32'(sum_y), 32'd0);
`ifdef SKIN_BBOX_EN
    chk({tag, "_bbox_xmax"}, 32'(bbox_xmax), 32'd0);
    chk({tag, "_bbox_ymax"}, 32'(bbox_ymax), 32'd0);
`endif
  endtask

  // Boundary vectors: {Y, Cb, Cr, expected mask}
  logic [7:0] bnd_y  [10] = '{8'd40, 8'd40, 8'd255, 8'd39, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
  logic [7:0] bnd_cb [10] = '{8'd77, 8'd127, 8'd127, 8'd100, 8'd76, 8'd128, 8'd100, 8'd100, 8'd77, 8'd127};
  logic [7:0] bnd_cr [10] = '{8'd133, 8'd173, 8'd133, 8'd150, 8'd150, 8'd150, 8'd174, 8'd132, 8'd173, 8'd133};
  logic       bnd_m  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    luma_ch   = 8'd0;
    cb_ch     = 8'd0;
    cr_ch     = 8'd0;
    idle(3);
    chk_zero_outputs("reset");
    rst = 1'b0;
    idle(2);

    // Threshold boundaries, issued in IDLE (mask only, no frame).
    for (int i = 0; i < 10; i++) px(bnd_y[i], bnd_cb[i], bnd_cr[i], 1'b0, bnd_m[i]);
    idle(2);

    // All-skin frame.
    exp_frame(8, 12, 4, 0, 3, 0, 1);
    frame_pat(8'hFF, 0);
    idle(2);

    // Single skin pixel at (3,1).
    exp_frame(1, 3, 1, 3, 3, 1, 1);
    frame_pat(8'h80, 0);
    idle(2);

    // Partial frame of 5 skin pixels abandoned by a new sof.
    for (int i = 0; i < 5; i++) px(8'd100, 8'd100, 8'd150, (i == 0), 1'b1);
    exp_frame(3, 4, 1, 1, 2, 0, 1);
    frame_pat(8'h26, 0);
    idle(2);

    // Zero-skin frame.
    exp_frame(0, 0, 0, 0, 0, 0, 0);
    frame_pat(8'h00, 0);
    idle(2);

    // Random pix_valid gaps: skin at (0,0),(3,0),(0,1),(2,1).
    exp_frame(4, 5, 2, 0, 3, 0, 1);
    frame_pat(8'h59, 3);
    idle(3);
    chk("hold_pix_count", 32'(pix_count), 32'd4);
    chk("hold_sum_x", 32'(sum_x), 32'd5);
    chk("hold_sum_y", 32'(sum_y), 32'd2);

    // Reset mid-frame: outputs clear at once, the frame is abandoned.
    for (int i = 0; i < 3; i++) px(8'd100, 8'd100, 8'd150, (i == 0), 1'b1);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    idle(1);
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 5; i++) px(8'd100, 8'd100, 8'd150, 1'b0, 1'b1);
    idle(3);
    exp_frame(8, 12, 4, 0, 3, 0, 1);
    frame_pat(8'hFF, 0);
    idle(5);

    chk("mask_queue_drained", mask_q.size(), 32'd0);
    chk("frame_queue_drained", frame_q.size(), 32'd0);
    chk("frame_done_total", frames_seen, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
